pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic parametrised inter-stage register for the MIPS pipeline (F/D, D/E, E/M, M/W).
- Supersedes the per-stage hand-written registers.
- Adds valid/ready handshake with a 1-entry skid buffer, bubble insertion that preserves PC/BD for CP0, exception-vector flush, and in-stage exception merging.

Parameters:
DATA_W, 96, width of the opaque stage payload (ALU/DM/RT/HILO/CP0 fields concatenated)
RESET_PC, 32'h0000_3000, out_pc value after reset
EXC_PC, 32'h0000_4180, out_pc value after req flush
SKID_EN, 1, 1 = 1-entry skid buffer present; 0 = in_ready tied to (out_ready | !out_valid)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req  in  1  exception request: flush all, load EXC_PC
flush  in  1  insert bubble (keep PC/BD)
stall  in  1  hold all state; in_ready forced 0
in_valid  in  1  upstream entry valid
in_ready  out  1  this stage can accept
in_pc  in  32  upstream PC
in_instr  in  32  upstream instruction
in_bd  in  1  upstream branch-delay-slot flag
in_exc_v  in  1  upstream exception pending
in_exc  in  5  upstream ExcCode
loc_exc_v  in  1  exception raised by producing stage this cycle
loc_exc  in  5  its ExcCode
in_data  in  DATA_W  payload
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_pc  out  32
out_instr  out  32
out_bd  out  1
out_exc_v  out  1
out_exc  out  5
out_data  out  DATA_W

Behaviour:
- Priority per cycle: reset > req > flush > stall > handshake.
- reset: out_valid=0, out_instr=0, out_pc=RESET_PC, out_bd=0, out_exc_v=0, out_exc=0, out_data=0, skid empty, in_ready=1.
- req: same as reset except out_pc=EXC_PC; skid cleared. Takes effect regardless of stall.
- flush: main reg loads bubble: out_valid=0, instr=0, data=0, exc_v=0, exc=0, out_pc=in_pc, out_bd=in_bd. Skid cleared. Upstream entry consumed (in_ready=1 this cycle).
- stall (no req/flush): every register and the skid hold; in_ready=0.
- Transfer: upstream fire = in_valid & in_ready; downstream fire = out_valid & out_ready.
- Capture merge:
  - exc_v = in_exc_v | loc_exc_v.
  - exc = in_exc if in_exc_v, else loc_exc (older exception wins).
  - in_valid=0 with the main register loading loads a bubble. PC/BD carry through exactly as for a flush.
- Main register loads when it is empty or downstream fires. Source is the skid when the skid is full, otherwise the input. Latency is 1 cycle input→output when unstalled.
- SKID_EN=1:
  - in_ready = skid empty (registered).
  - If upstream fires while out_valid & !out_ready, the entry goes to the skid and in_ready falls next cycle.
  - On downstream fire with the skid full: skid→main, skid empties, in_ready rises next cycle.
  - Skid full with a simultaneous upstream fire cannot occur because in_ready=0.
- SKID_EN=0: in_ready = !stall & (out_ready | !out_valid); no skid state.
- Entry order: strictly FIFO, no loss, no duplication.
- reset or req asserted mid-transfer discards both held entries.

Decomposition:
- Shared package mips_pkg holds:
  - constants RESET_PC, EXC_PC, ExcCode values (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12);
  - typedef stage_meta_t {pc, instr, bd, exc_v, exc}.
- One natural sub-module, stage_skid_buf: a 1-entry buffer of stage_meta_t plus data, instantiated when SKID_EN=1.

Test Plan:
- Reset then in_valid=1, in_pc=0x3004, in_instr=0x24010001, out_ready=1 → next cycle out_valid=1, out_pc=0x3004, out_instr=0x24010001. Before that cycle: out_pc=0x3000, out_valid=0.
- out_ready=0 with entries A(pc 0x3008) then B(0x300C) offered → A in main, B in skid, in_ready=0. Raise out_ready → A, then B, in order; in_ready=1 one cycle after B moves.
- flush with in_pc=0x3010, in_bd=1 → out_valid=0, out_instr=0, out_pc=0x3010, out_bd=1, out_exc_v=0.
- req during stall, skid full → next cycle out_pc=0x4180, out_valid=0, skid empty, in_ready=1.
- in_exc_v=1 in_exc=4 with loc_exc_v=1 loc_exc=12 → out_exc_v=1, out_exc=4. With in_exc_v=0 → out_exc=12.
- stall held 3 cycles with in_valid=1 → outputs unchanged, in_ready=0 throughout, no entry lost after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Holds the reset and exception PC values, the CP0 ExcCode values and the
// per-entry metadata record that travels alongside each stage payload.
package mips_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        logic        exc_v;
        logic [4:0]  exc;
    } stage_meta_t;

endpackage

// File: rtl/stage_skid_buf.sv
// One-entry skid buffer for a pipeline stage register.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear        drop the held entry (exception or flush)
//   load         capture meta_in/data_in, buffer becomes full
//   pop          entry has been moved to the main register, buffer empties
//   full         buffer holds an entry
//   meta, data   held entry
module stage_skid_buf
    import mips_pkg::*;
#(
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              pop,
    input  stage_meta_t       meta_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    output stage_meta_t       meta,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            full <= 1'b0;
            meta <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            meta <= meta_in;
            data <= data_in;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register for the MIPS pipeline (F/D, D/E, E/M, M/W).
// Valid/ready handshake with an optional one-entry skid buffer, bubble
// insertion that keeps PC/BD for CP0, exception-vector flush (req) and merging
// of the producing stage's exception into the entry being captured.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req                   exception: drop everything, out_pc <= EXC_PC
//   flush                 load a bubble carrying in_pc/in_bd
//   stall                 hold all state, in_ready low
//   in_valid/in_ready     upstream handshake
//   in_pc..in_data        upstream entry, loc_exc_v/loc_exc local exception
//   out_valid/out_ready   downstream handshake
//   out_pc..out_data      registered entry
module pipe_stage_reg
    import mips_pkg::*;
#(
    parameter int          DATA_W   = 96,
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [31:0] EXC_PC   = mips_pkg::EXC_PC,
    parameter bit          SKID_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic              in_bd,
    input  logic              in_exc_v,
    input  logic [4:0]        in_exc,
    input  logic              loc_exc_v,
    input  logic [4:0]        loc_exc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic              out_bd,
    output logic              out_exc_v,
    output logic [4:0]        out_exc,
    output logic [DATA_W-1:0] out_data
);

    stage_meta_t       cap_meta, main_meta, skid_meta;
    logic [DATA_W-1:0] cap_data, main_data, skid_data;
    logic              main_vld, skid_full;
    logic              hs_ready, main_load, up_fire, skid_load, skid_pop;

    // Entry as it would be captured from upstream. With in_valid low this is
    // a bubble that still carries PC/BD so CP0 sees the right EPC/BD.
    always_comb begin
        cap_meta.pc    = in_pc;
        cap_meta.bd    = in_bd;
        cap_meta.instr = in_valid ? in_instr : 32'd0;
        cap_meta.exc_v = in_valid & (in_exc_v | loc_exc_v);
        // Older (upstream) exception takes precedence over the local one.
        cap_meta.exc   = !in_valid ? 5'd0 : (in_exc_v ? in_exc : loc_exc);
        cap_data       = in_valid ? in_data : '0;
    end

    always_comb begin
        hs_ready  = SKID_EN ? !skid_full : (out_ready | !main_vld);
        // reset/req/flush all discard the upstream entry, so it is consumed.
        in_ready  = reset | req | flush | (!stall & hs_ready);
        main_load = !stall & (!main_vld | out_ready);
        up_fire   = in_valid & in_ready;
        skid_load = SKID_EN & !req & !flush & !stall & up_fire & !main_load;
        skid_pop  = main_load & skid_full;
    end

    generate
        if (SKID_EN) begin : g_skid
            stage_skid_buf #(.DATA_W(DATA_W)) u_skid (
                .clk     (clk),
                .reset   (reset),
                .clear   (req | flush),
                .load    (skid_load),
                .pop     (skid_pop),
                .meta_in (cap_meta),
                .data_in (cap_data),
                .full    (skid_full),
                .meta    (skid_meta),
                .data    (skid_data)
            );
        end else begin : g_noskid
            assign skid_full = 1'b0;
            assign skid_meta = '0;
            assign skid_data = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || req) begin
            main_vld  <= 1'b0;
            main_meta <= '0;
            main_meta.pc <= reset ? RESET_PC : EXC_PC;
            main_data <= '0;
        end else if (flush) begin
            main_vld  <= 1'b0;
            main_meta <= '0;
            main_meta.pc <= in_pc;
            main_meta.bd <= in_bd;
            main_data <= '0;
        end else if (main_load) begin
            if (skid_full) begin
                main_vld  <= 1'b1;
                main_meta <= skid_meta;
                main_data <= skid_data;
            end else begin
                main_vld  <= in_valid;
                main_meta <= cap_meta;
                main_data <= cap_data;
            end
        end
    end

    assign out_valid = main_vld;
    assign out_pc    = main_meta.pc;
    assign out_instr = main_meta.instr;
    assign out_bd    = main_meta.bd;
    assign out_exc_v = main_meta.exc_v;
    assign out_exc   = main_meta.exc;
    assign out_data  = main_data;

endmodule
